riscv_ctrl_seq: RTL and testbench
=================================

RISCV_CTRL_SEQ -- requirements
Module: riscv_ctrl_seq

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 32, meaning instruction-memory depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 15, meaning maximum cycles spent in FETCH without imem_ack (1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1 bit: level enable; the core sequences instructions while high.
REQ-006 SHALL have port halt_clr, input, 1 bit: single-cycle pulse that releases HALT.
REQ-007 SHALL have port imem_req, output, 1 bit: fetch request, high exactly while in FETCH.
REQ-008 SHALL have port imem_addr, output, log2(IMEM_DEPTH) bits: word index, equal to pc>>2.
REQ-009 SHALL have port imem_ack, input, 1 bit: fetch data valid.
REQ-010 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-011 SHALL have port instr, output, 32 bits: instruction register (IR).
REQ-012 SHALL have port pc, output, 32 bits: program counter, word aligned.
REQ-013 SHALL have port alu_op, output, 2 bits: 00 ADD, 01 SUB, 10 ADDI, 11 none.
REQ-014 SHALL have ports rf_we and gpio_we, outputs, 1 bit each: register-file write strobe and GPIO update strobe.
REQ-015 SHALL have ports busy, illegal and fault, outputs, 1 bit each; SHALL have port retired_cnt, output, 16 bits.

Function
REQ-016 SHALL implement the states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-017 IDLE: when run=1, SHALL go to FETCH on the next edge; otherwise SHALL stay in IDLE.
REQ-018 FETCH: imem_req=1; on imem_ack=1, SHALL load IR from imem_rdata and go to DECODE; imem_req SHALL be 0 in the following cycle.
REQ-019 FETCH: if FETCH_TIMEOUT cycles pass with no ack, SHALL set fault=1 and go to HALT; the timeout counter SHALL clear on each entry to FETCH.
REQ-020 DECODE (1 cycle): opcode 0010011 is ADDI; opcode 0110011 with funct3=000 is ADD when funct7=0000000 and SUB when funct7=0100000; any other encoding SHALL set illegal=1 and go to HALT without any write strobes.
REQ-021 EXEC (1 cycle): alu_op SHALL hold the decoded operation; alu_op SHALL be 11 in every other state.
REQ-022 WB (1 cycle): rf_we=1 and gpio_we=1 only if rd (IR[11:7]) is nonzero; the PC SHALL advance by 4; retired_cnt SHALL increment by 1.
REQ-023 PC wrap: when pc=4*(IMEM_DEPTH-1), WB SHALL set pc to 0.
REQ-024 After WB, SHALL go to FETCH if run=1, else to IDLE; a legal instruction SHALL take 4 cycles when ack arrives in the first FETCH cycle.
REQ-025 run falling mid-instruction: the current instruction SHALL complete through WB, then the FSM SHALL go to IDLE.
REQ-026 imem_ack outside FETCH SHALL be ignored.
REQ-027 HALT: all strobes 0 and busy=1; halt_clr SHALL clear illegal and fault and go to IDLE, with pc unchanged.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 retired_cnt SHALL wrap from 0xFFFF to 0.

Reset
REQ-030 reset_n=0 SHALL immediately force state=IDLE, pc=0, IR=0, alu_op=11, retired_cnt=0, and all other outputs to 0, including during any in-flight fetch.
REQ-031 After reset_n is released, no write strobe SHALL assert before a completed fetch.

Configuration
REQ-032 With macro RISCV_CTRL_SEQ_RETIRE_CNT_EN defined, retired_cnt SHALL behave per REQ-022/REQ-029; without it, the port SHALL remain present and be tied to 0, with no counter flops.

Verification
REQ-033 Program ADDI x1,x0,2 / ADDI x2,x0,3 / ADD x3,x1,x2 / SUB x3,x1,x2, acks immediate, run=1 -> alu_op sequence 10,10,00,01; rf_we pulses every 4 cycles; pc=16 and retired_cnt=4 after 16 cycles.
REQ-034 Word 0x00000000 fetched -> illegal=1, HALT, no rf_we; halt_clr pulse -> IDLE, illegal=0, pc unchanged.
REQ-035 imem_ack withheld -> fault=1 after 15 FETCH cycles; an ack arriving afterwards is ignored.
REQ-036 ADDI x0,x0,5 -> rf_we=0 and gpio_we=0 in WB; pc still advances by 4.
REQ-037 Run from pc=124 with IMEM_DEPTH=32 -> pc=0 after WB; separately, reset_n low during FETCH -> IDLE, pc=0, imem_req=0 with no clock edge.

Source files
------------

// File: rtl/riscv_ctrl_seq.sv
// Multi-cycle control sequencer for a tiny RV32 subset (ADD, SUB, ADDI): IDLE/FETCH/DECODE/EXEC/WB/HALT.
// Define RISCV_CTRL_SEQ_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired_cnt is tied to 0.
module riscv_ctrl_seq #(
    parameter int IMEM_DEPTH    = 32,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic                          halt_clr,
    output logic                          imem_req,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic                          imem_ack,
    input  logic [31:0]                   imem_rdata,
    output logic [31:0]                   instr,
    output logic [31:0]                   pc,
    output logic [1:0]                    alu_op,
    output logic                          rf_we,
    output logic                          gpio_we,
    output logic                          busy,
    output logic                          illegal,
    output logic                          fault,
    output logic [15:0]                   retired_cnt
);

    localparam int          AW      = $clog2(IMEM_DEPTH);
    localparam logic [31:0] PC_LAST = 32'(4 * (IMEM_DEPTH - 1));
    localparam logic [7:0]  TO_LAST = 8'(FETCH_TIMEOUT - 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [7:0]  tcnt;
    logic [1:0]  dec_op;
    logic        dec_bad;
    logic        timeout_hit;
    logic        rd_nonzero;
    logic [31:0] pc_next;

    assign imem_addr   = pc[AW+1:2];
    assign timeout_hit = (tcnt == TO_LAST);
    assign rd_nonzero  = (instr[11:7] != 5'd0);
    assign pc_next     = (pc == PC_LAST) ? 32'd0 : pc + 32'd4;

    always_comb begin
        dec_op  = OP_NONE;
        dec_bad = 1'b1;
        if (instr[6:0] == 7'b0010011) begin
            dec_op  = OP_ADDI;
            dec_bad = 1'b0;
        end else if (instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000) begin
            if (instr[31:25] == 7'b0000000) begin
                dec_op  = OP_ADD;
                dec_bad = 1'b0;
            end else if (instr[31:25] == 7'b0100000) begin
                dec_op  = OP_SUB;
                dec_bad = 1'b0;
            end
        end
    end

    // A dropping run only matters at IDLE and at the end of WB, so an instruction always completes.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (run) state_n = S_FETCH;
            S_FETCH: begin
                if (imem_ack)         state_n = S_DECODE;
                else if (timeout_hit) state_n = S_HALT;
            end
            S_DECODE: state_n = dec_bad ? S_HALT : S_EXEC;
            S_EXEC:   state_n = S_WB;
            S_WB:     state_n = run ? S_FETCH : S_IDLE;
            S_HALT:   if (halt_clr) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is valid for the whole cycle of its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pc       <= 32'd0;
            instr    <= 32'd0;
            tcnt     <= 8'd0;
            imem_req <= 1'b0;
            alu_op   <= OP_NONE;
            rf_we    <= 1'b0;
            gpio_we  <= 1'b0;
            busy     <= 1'b0;
            illegal  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            imem_req <= (state_n == S_FETCH);
            busy     <= (state_n != S_IDLE);
            alu_op   <= (state_n == S_EXEC) ? dec_op : OP_NONE;
            rf_we    <= (state_n == S_WB) && rd_nonzero;
            gpio_we  <= (state_n == S_WB) && rd_nonzero;
            tcnt     <= (state == S_FETCH) ? tcnt + 8'd1 : 8'd0;
            if (state == S_FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == S_FETCH && !imem_ack && timeout_hit)
                fault <= 1'b1;
            if (state == S_DECODE && dec_bad)
                illegal <= 1'b1;
            if (state == S_WB)
                pc <= pc_next;
            if (state == S_HALT && halt_clr) begin
                illegal <= 1'b0;
                fault   <= 1'b0;
            end
        end
    end

`ifdef RISCV_CTRL_SEQ_RETIRE_CNT_EN
    logic [15:0] rcnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rcnt <= 16'd0;
        else if (state == S_WB)
            rcnt <= rcnt + 16'd1;
    end

    assign retired_cnt = rcnt;
`else
    assign retired_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// Bench for riscv_ctrl_seq: memory responder pushes expected retirements, a monitor pops and checks them.
// Directed scenarios cover reset, the four-instruction program, illegal/timeout halts, rd=x0 and pc wrap.
module tb_riscv_ctrl_seq;

    localparam int DEPTH  = 32;
    localparam int TO     = 15;
    localparam int AW     = $clog2(DEPTH);
    localparam int M_NORM = 0;
    localparam int M_HOLD = 1;
    localparam int M_SPUR = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          run = 1'b0;
    logic          halt_clr = 1'b0;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = 32'd0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [1:0]    alu_op;
    logic          rf_we;
    logic          gpio_we;
    logic          busy;
    logic          illegal;
    logic          fault;
    logic [15:0]   retired_cnt;

    riscv_ctrl_seq #(.IMEM_DEPTH(DEPTH), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .halt_clr(halt_clr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .pc(pc), .alu_op(alu_op),
        .rf_we(rf_we), .gpio_we(gpio_we), .busy(busy), .illegal(illegal),
        .fault(fault), .retired_cnt(retired_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state and scoreboard ----------------
    typedef struct packed {
        logic        bad;
        logic [1:0]  op;
        logic        we;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] word;
        logic [15:0] cnt;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    logic [31:0]  mem[DEPTH];
    logic [31:0]  m_pc = 32'd0;
    logic [31:0]  m_ir = 32'd0;
    logic [15:0]  m_cnt = 16'd0;
    int           mode = M_NORM;
    bit           rand_delay = 0;
    bit           spur_en = 0;
    bit           auto_clr = 0;
    bit           gap_chk = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of a word: 10 ADDI, 00 ADD, 01 SUB, 11 not executable.
    function automatic logic [1:0] classify(input logic [31:0] w);
        if (w[6:0] == 7'b0010011) return 2'b10;
        if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000) begin
            if (w[31:25] == 7'b0000000) return 2'b00;
            if (w[31:25] == 7'b0100000) return 2'b01;
        end
        return 2'b11;
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 2))
            0:       return enc_i(rd, rs1, 12'($urandom));
            1:       return enc_r(7'h00, rs2, rs1, rd);
            default: return enc_r(7'h20, rs2, rs1, rd);
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        if ($urandom_range(0, 5) != 0) return rand_legal();
        case ($urandom_range(0, 2))
            0:       w = $urandom;
            1:       w = enc_r(7'h01, 5'd3, 5'd2, 5'd1);
            default: w = enc_r(7'h00, 5'd3, 5'd2, 5'd1) | 32'h0000_4000;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef RISCV_CTRL_SEQ_RETIRE_CNT_EN
        return c;
`else
        return 16'd0 & c;
`endif
    endfunction

    // ---------------- memory responder (issues fetch data, pushes expectations) ----------------
    initial begin
        int wait_n;
        int dly;
        logic [31:0] w;
        exp_t e;
        wait_n = 0;
        dly = 0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (!reset_n) begin
                wait_n = 0;
                dly = 0;
            end else if (imem_req) begin
                if (mode == M_NORM) begin
                    if (wait_n >= dly) begin
                        check("imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
                        w = mem[m_pc[AW+1:2]];
                        imem_ack = 1'b1;
                        imem_rdata = w;
                        m_ir = w;
                        e = '0;
                        e.word = w;
                        e.pc = m_pc;
                        e.op = classify(w);
                        if (e.op == 2'b11) begin
                            e.bad = 1'b1;
                        end else begin
                            e.we = (w[11:7] != 5'd0);
                            e.npc = (m_pc + 32'd4) % 32'(4 * DEPTH);
                            m_cnt = m_cnt + 16'd1;
                            e.cnt = m_cnt;
                            m_pc = e.npc;
                        end
                        exp_q.push_back(e);
                        wait_n = 0;
                        dly = rand_delay ? int'($urandom_range(0, 3)) : 0;
                    end else begin
                        wait_n++;
                    end
                end
            end else if (mode == M_SPUR || (spur_en && $urandom_range(0, 3) == 0)) begin
                imem_ack = 1'b1;
                imem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor (pops and compares) ----------------
    initial begin
        int phase;
        int last_wb;
        bit prev_ill;
        exp_t cur;
        phase = 0;
        last_wb = -1;
        prev_ill = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                phase = 0;
                last_wb = -1;
                prev_ill = 1'b0;
                continue;
            end
            case (phase)
                0: begin
                    check("no_strobe_outside_wb", {30'd0, rf_we, gpio_we}, 32'd0);
                    if (alu_op != 2'b11) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL exec_unexpected: alu_op=%0d with no fetch pending (t=%0t)", alu_op, $time);
                        end else begin
                            cur = exp_q.pop_front();
                            check("exec_kind", 32'(cur.bad), 32'd0);
                            check("exec_alu_op", 32'(alu_op), 32'(cur.op));
                            check("exec_instr", instr, cur.word);
                            check("exec_pc", pc, cur.pc);
                            check("exec_imem_req", 32'(imem_req), 32'd0);
                            phase = 1;
                        end
                    end else if (illegal && !prev_ill) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL illegal_unexpected: illegal=1 with no fetch pending (t=%0t)", $time);
                        end else begin
                            cur = exp_q.pop_front();
                            check("illegal_kind", 32'(cur.bad), 32'd1);
                            check("illegal_instr", instr, cur.word);
                            check("illegal_pc", pc, cur.pc);
                            check("illegal_busy", 32'(busy), 32'd1);
                        end
                    end
                end
                1: begin
                    check("wb_rf_we", 32'(rf_we), 32'(cur.we));
                    check("wb_gpio_we", 32'(gpio_we), 32'(cur.we));
                    check("wb_alu_op", 32'(alu_op), 32'd3);
                    check("wb_busy", 32'(busy), 32'd1);
                    if (gap_chk && last_wb >= 0) check("wb_spacing", 32'(cyc - last_wb), 32'd4);
                    last_wb = cyc;
                    phase = 2;
                end
                default: begin
                    check("post_wb_pc", pc, cur.npc);
                    check("post_wb_retired", 32'(retired_cnt), 32'(exp_cnt(cur.cnt)));
                    check("post_wb_rf_we", 32'(rf_we), 32'd0);
                    phase = 0;
                end
            endcase
            prev_ill = illegal;
        end
    end

    // ---------------- halt release driver for the random phase ----------------
    initial forever begin
        @(negedge clk);
        if (!auto_clr) continue;
        if (halt_clr) begin
            halt_clr = 1'b0;
        end else if (reset_n && (illegal || fault)) begin
            halt_clr = 1'b1;
            mem[m_pc[AW+1:2]] = rand_legal();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        halt_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        m_pc = 32'd0;
        m_cnt = 16'd0;
        m_ir = 32'd0;
        reset_n = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        halt_clr = 1'b1;
        @(negedge clk);
        halt_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd3);
        check({tag, "_strobes"}, {30'd0, rf_we, gpio_we}, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_retired"}, 32'(retired_cnt), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit seen;
        logic [31:0] p0;

        for (int i = 0; i < DEPTH; i++) mem[i] = rand_legal();
        mem[0] = enc_i(5'd1, 5'd0, 12'd2);
        mem[1] = enc_i(5'd2, 5'd0, 12'd3);
        mem[2] = enc_r(7'h00, 5'd2, 5'd1, 5'd3);
        mem[3] = enc_r(7'h20, 5'd2, 5'd1, 5'd3);

        // Asynchronous reset, observed before any clock edge.
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        check("reset_held_busy", 32'(busy), 32'd0);
        check("reset_held_req", 32'(imem_req), 32'd0);
        exp_q.delete();
        m_pc = 32'd0;
        m_cnt = 16'd0;
        m_ir = 32'd0;

        // ADDI, ADDI, ADD, SUB with immediate acks: four cycles each.
        gap_chk = 1;
        reset_n = 1'b1;
        run = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        check("prog_pc_after_16", pc, 32'd16);
        check("prog_retired_after_16", 32'(retired_cnt), 32'(exp_cnt(16'd4)));
        run = 1'b0;
        wait_idle("prog_drain", 20);
        gap_chk = 0;
        check("prog_pc_idle", pc, m_pc);

        // All-zero word is not executable.
        mem[m_pc[AW+1:2]] = 32'd0;
        @(negedge clk);
        run = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (illegal) seen = 1;
        end
        run = 1'b0;
        check("illegal_seen", 32'(seen), 32'd1);
        check("illegal_halt_busy", 32'(busy), 32'd1);
        check("illegal_halt_req", 32'(imem_req), 32'd0);
        check("illegal_halt_fault", 32'(fault), 32'd0);
        repeat (2) @(negedge clk);
        check("illegal_still_halted", 32'(busy), 32'd1);
        check("illegal_no_rf_we", 32'(rf_we), 32'd0);
        pulse_clr();
        check("illegal_cleared", 32'(illegal), 32'd0);
        check("illegal_clr_idle", 32'(busy), 32'd0);
        check("illegal_clr_pc", pc, m_pc);

        // Withheld ack: fault after exactly TO cycles in FETCH, later acks ignored.
        mode = M_HOLD;
        @(negedge clk);
        run = 1'b1;
        n = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (fault) seen = 1;
            else if (imem_req) n++;
        end
        run = 1'b0;
        check("timeout_fault", 32'(seen), 32'd1);
        check("timeout_cycles", 32'(n), 32'(TO));
        check("timeout_req_low", 32'(imem_req), 32'd0);
        check("timeout_busy", 32'(busy), 32'd1);
        check("timeout_not_illegal", 32'(illegal), 32'd0);
        mode = M_SPUR;
        repeat (4) @(negedge clk);
        check("late_ack_instr", instr, m_ir);
        check("late_ack_fault", 32'(fault), 32'd1);
        check("late_ack_busy", 32'(busy), 32'd1);
        check("late_ack_pc", pc, m_pc);
        mode = M_NORM;
        pulse_clr();
        check("fault_cleared", 32'(fault), 32'd0);
        check("fault_clr_idle", 32'(busy), 32'd0);
        check("fault_clr_pc", pc, m_pc);

        // ADDI x0,x0,5: no strobes, pc still advances; run is only a one-cycle pulse.
        p0 = m_pc;
        mem[m_pc[AW+1:2]] = enc_i(5'd0, 5'd0, 12'd5);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_idle("x0_drain", 20);
        check("x0_pc_advance", pc, (p0 + 32'd4) % 32'(4 * DEPTH));

        // Run all the way around the memory, then reset in the middle of a fetch.
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_legal();
        do_reset();
        run = 1'b1;
        repeat (1 + 4 * DEPTH) @(posedge clk);
        #1;
        check("wrap_pc", pc, 32'((4 * DEPTH) % (4 * DEPTH)));
        check("wrap_retired", 32'(retired_cnt), 32'(exp_cnt(16'(DEPTH))));
        repeat (4) @(posedge clk);
        #1;
        check("inflight_req", 32'(imem_req), 32'd1);
        check("inflight_pc", pc, 32'd4);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("inflight_reset");
        run = 1'b0;
        @(negedge clk);
        do_reset();

        // Random program with illegal words, variable ack latency, stray acks and a flickering run.
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        rand_delay = 1;
        spur_en = 1;
        auto_clr = 1;
        do_reset();
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            run = ($urandom_range(0, 9) != 0);
        end
        run = 1'b0;
        wait_idle("random_drain", 60);
        repeat (3) @(negedge clk);
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);
        check("random_idle_pc", pc, m_pc);
        auto_clr = 0;
        spur_en = 0;
        rand_delay = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
